control_sequencer: RTL and testbench

- Microcode sequencer for the 8-bit bus CPU.
- Steps through fetch/execute microsteps and drives the load/output-enable strobes of every bus register, the ALU, the PC, the output register and the flags register.
- Directly upstream of the register instances: its strobes drive their load inputs.
- Consumes the opcode nibble from the instruction register and the carry/zero bits from the flags register.

---
 rtl/control_sequencer.sv | 141 ++++++++++++++
 tb/tb_control_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode step sequencer driving the bus CPU control word
`timescale 1ns/1ps
module control_sequencer #(
    parameter bit EARLY_END = 1'b1,
    parameter int NSTEPS    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam step_t LAST_STEP = step_t'(3'(NSTEPS - 1));

    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    step_t       step_q, step_d;
    logic        halted_q, halted_d;
    step_t       last_step;
    logic [15:0] ctrl_raw;

    // step counter and halt flag register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // microcode decode, next-step selection and reset/halt gating of the control word
    always_comb begin
        step_d    = step_q;
        halted_d  = halted_q;
        ctrl_raw  = '0;
        last_step = T2;

        case (opcode)
            OP_ADD, OP_SUB: last_step = T4;
            OP_LDA, OP_STA: last_step = T3;
            default:        last_step = T2;
        endcase

        case (step_q)
            T0: ctrl_raw = CO | MI;
            T1: ctrl_raw = RO | II | CE;
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_raw = IO | MI;
                    OP_LDI: ctrl_raw = IO | AI;
                    OP_JMP: ctrl_raw = IO | J;
                    OP_JC:  ctrl_raw = carry_flag ? (IO | J) : 16'h0000;
                    OP_JZ:  ctrl_raw = zero_flag  ? (IO | J) : 16'h0000;
                    OP_OUT: ctrl_raw = AO | OI;
                    OP_HLT: ctrl_raw = HLT;
                    default: ctrl_raw = 16'h0000;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: ctrl_raw = RO | AI;
                    OP_ADD: ctrl_raw = RO | BI;
                    OP_SUB: ctrl_raw = RO | BI | SU;
                    OP_STA: ctrl_raw = AO | RI;
                    default: ctrl_raw = 16'h0000;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_ADD: ctrl_raw = EO | AI | FI;
                    OP_SUB: ctrl_raw = EO | AI | SU | FI;
                    default: ctrl_raw = 16'h0000;
                endcase
            end
            default: ctrl_raw = 16'h0000;
        endcase

        // out-of-range step values also land on T0 through the >= comparisons
        if (!halted_q) begin
            if (step_q == T2 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else if (EARLY_END ? (step_q >= last_step) : (step_q >= LAST_STEP)) begin
                step_d = T0;
            end else begin
                step_d = step_t'(3'(step_q) + 3'd1);
            end
        end

        if (!rst_n) begin
            ctrl = 16'h0000;
        end else if (halted_q) begin
            ctrl = HLT;
        end else begin
            ctrl = ctrl_raw;
        end
    end

    assign step   = 3'(step_q);
    assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer (both EARLY_END settings)
`timescale 1ns/1ps
module tb_control_sequencer;

    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

    typedef struct {
        bit          sel;
        bit          chk_state;
        logic [15:0] ctrl;
        logic [2:0]  step;
        logic        halted;
    } exp_t;

    logic            clk = 1'b0;
    logic [1:0]      rstn;
    logic [1:0][3:0] opc;
    logic [1:0]      cf;
    logic [1:0]      zf;
    wire  [15:0]     ctrl0, ctrl1;
    wire  [2:0]      step0, step1;
    wire             halted0, halted1;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    control_sequencer #(.EARLY_END(1'b0), .NSTEPS(5)) dut0 (
        .clk(clk), .rst_n(rstn[0]), .opcode(opc[0]), .carry_flag(cf[0]), .zero_flag(zf[0]),
        .ctrl(ctrl0), .step(step0), .halted(halted0)
    );

    control_sequencer #(.EARLY_END(1'b1), .NSTEPS(5)) dut1 (
        .clk(clk), .rst_n(rstn[1]), .opcode(opc[1]), .carry_flag(cf[1]), .zero_flag(zf[1]),
        .ctrl(ctrl1), .step(step1), .halted(halted1)
    );

    // execute-phase words of the instruction table; k is the microstep 2..4
    function automatic logic [15:0] exec_word(logic [3:0] op, int k, logic c, logic z);
        logic [15:0] w[3];
        case (op)
            4'd1:    w = '{IO | MI, RO | AI, 16'h0};
            4'd2:    w = '{IO | MI, RO | BI, EO | AI | FI};
            4'd3:    w = '{IO | MI, RO | BI | SU, EO | AI | SU | FI};
            4'd4:    w = '{IO | MI, AO | RI, 16'h0};
            4'd5:    w = '{IO | AI, 16'h0, 16'h0};
            4'd6:    w = '{IO | J, 16'h0, 16'h0};
            4'd7:    w = '{c ? (IO | J) : 16'h0, 16'h0, 16'h0};
            4'd8:    w = '{z ? (IO | J) : 16'h0, 16'h0, 16'h0};
            4'd14:   w = '{AO | OI, 16'h0, 16'h0};
            4'd15:   w = '{HLT, 16'h0, 16'h0};
            default: w = '{16'h0, 16'h0, 16'h0};
        endcase
        return w[k-2];
    endfunction

    // last non-empty step of the static table (conditional jumps counted as taken), never before T2
    function automatic int table_last(logic [3:0] op);
        int last = 2;
        for (int k = 3; k <= 4; k++)
            if (exec_word(op, k, 1'b1, 1'b1) != 16'h0) last = k;
        return last;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, req);
        end
    endtask

    // one clock cycle of stimulus with its expected response queued
    task automatic cycle(bit s, logic [3:0] op, logic c, logic z, logic r, exp_t e);
        @(posedge clk);
        #1;
        rstn[s] = r;
        opc[s]  = op;
        cf[s]   = c;
        zf[s]   = z;
        sb.push_back(e);
    endtask

    task automatic instr(bit s, logic [3:0] op, logic c, logic z, int max_cyc);
        int          last;
        logic [3:0]  o;
        logic        cc, zz;
        logic [15:0] w;
        last = s ? table_last(op) : 4;
        for (int k = 0; k <= last && k < max_cyc; k++) begin
            o  = (k < 2) ? 4'($urandom) : op;
            cc = (k == 2) ? c : 1'($urandom);
            zz = (k == 2) ? z : 1'($urandom);
            w  = (k == 0) ? (CO | MI) : (k == 1) ? (RO | II | CE) : exec_word(op, k, cc, zz);
            cycle(s, o, cc, zz, 1'b1, '{s, 1'b1, w, 3'(k), 1'b0});
            if (op == 4'hF && k == 2) break;
        end
    endtask

    task automatic halt_hold(bit s, int n, bit rand_op);
        logic [3:0] o;
        for (int i = 0; i < n; i++) begin
            o = rand_op ? 4'($urandom) : 4'b0001;
            cycle(s, o, 1'($urandom), 1'($urandom), 1'b1, '{s, 1'b1, HLT, 3'd2, 1'b1});
        end
    endtask

    task automatic reset_pulse(bit s);
        cycle(s, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0, '{s, 1'b0, 16'h0, 3'd0, 1'b0});
    endtask

    task automatic random_run(bit s, int n);
        logic [3:0] op;
        int         lim;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom);
            if (op == 4'hF) begin
                instr(s, op, 1'($urandom), 1'($urandom), 99);
                halt_hold(s, int'($urandom_range(1, 4)), 1'b1);
                reset_pulse(s);
            end else if ($urandom_range(0, 19) == 0) begin
                lim = int'($urandom_range(1, 4));
                instr(s, op, 1'($urandom), 1'($urandom), lim);
                reset_pulse(s);
            end else begin
                instr(s, op, 1'($urandom), 1'($urandom), 99);
            end
        end
    endtask

    // monitor: every falling edge compares the selected DUT against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    check("ctrl_ee1", ctrl1, e.ctrl);
                    if (e.chk_state) begin
                        check("step_ee1", 16'(step1), 16'(e.step));
                        check("halted_ee1", 16'(halted1), 16'(e.halted));
                    end
                end else begin
                    check("ctrl_ee0", ctrl0, e.ctrl);
                    if (e.chk_state) begin
                        check("step_ee0", 16'(step0), 16'(e.step));
                        check("halted_ee0", 16'(halted0), 16'(e.halted));
                    end
                end
            end
        end
    end

    // stimulus: directed table for EARLY_END=1, then random; then the same for EARLY_END=0
    initial begin
        rstn = 2'b00;
        opc  = '0;
        cf   = 2'b00;
        zf   = 2'b00;

        reset_pulse(1'b1);
        reset_pulse(1'b1);
        instr(1'b1, 4'd1, 1'b0, 1'b0, 99);
        instr(1'b1, 4'd3, 1'b0, 1'b0, 99);
        instr(1'b1, 4'd2, 1'b1, 1'b1, 99);
        instr(1'b1, 4'd7, 1'b1, 1'b0, 99);
        instr(1'b1, 4'd7, 1'b0, 1'b1, 99);
        instr(1'b1, 4'd8, 1'b0, 1'b1, 99);
        instr(1'b1, 4'd8, 1'b1, 1'b0, 99);
        instr(1'b1, 4'd14, 1'b0, 1'b0, 99);
        instr(1'b1, 4'd4, 1'b0, 1'b0, 99);
        instr(1'b1, 4'd5, 1'b0, 1'b0, 99);
        instr(1'b1, 4'd6, 1'b0, 1'b0, 99);
        instr(1'b1, 4'd0, 1'b0, 1'b0, 99);
        instr(1'b1, 4'd11, 1'b0, 1'b0, 99);
        instr(1'b1, 4'd15, 1'b0, 1'b0, 99);
        halt_hold(1'b1, 10, 1'b0);
        reset_pulse(1'b1);
        instr(1'b1, 4'd2, 1'b0, 1'b0, 4);
        reset_pulse(1'b1);
        random_run(1'b1, 150);
        reset_pulse(1'b1);

        instr(1'b0, 4'd5, 1'b0, 1'b0, 99);
        instr(1'b0, 4'd3, 1'b0, 1'b0, 99);
        instr(1'b0, 4'd7, 1'b0, 1'b0, 99);
        instr(1'b0, 4'd15, 1'b0, 1'b0, 99);
        halt_hold(1'b0, 5, 1'b1);
        reset_pulse(1'b0);
        random_run(1'b0, 80);

        repeat (3) @(posedge clk);
        check("sb_drain", 16'(sb.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
